token_fsm: RTL
==============

TOKEN_FSM -- requirements
Module: token_fsm

Interface
REQ-001 Parameter MODE, default 0: token grammar; 0 = letters+ digits+ ([A-Za-z]+[0-9]+), 1 = C identifier ([A-Za-z_][A-Za-z0-9_]*).
REQ-002 Parameter MAX_LEN, default 32: longest accepted token, in characters.
REQ-003 Parameter LEN_W, default 6: tok_len width; SHALL satisfy 2^LEN_W > MAX_LEN.
REQ-004 Parameter CNT_W, default 16: tok_count width.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_char is consumed on a rising edge only when 1.
REQ-008 in_char  input  8  ASCII character.
REQ-009 cnt_clr  input  1  synchronous clear of tok_count.
REQ-010 match  output  1  registered; 1 when the consumed stream ends in a complete token of the selected grammar.
REQ-011 tok_done  output  1  registered one-cycle pulse; a matched token was terminated by a delimiter.
REQ-012 tok_len  output  LEN_W  registered; length of the current or most recent token.
REQ-013 tok_count  output  CNT_W  registered; number of tok_done pulses since reset or clear.
REQ-014 overflow  output  1  registered one-cycle pulse; token exceeded MAX_LEN.

Function
REQ-015 Classes: alpha = 0x41-0x5A or 0x61-0x7A; digit = 0x30-0x39; underscore = 0x5F, token class in MODE 1 only; delimiter = any other character.
REQ-016 States: IDLE, ALPHA, DIGIT (MODE 0); IDLE, IDENT (MODE 1); SKIP (both modes).
REQ-017 in_valid=0: state, tok_len, match held; tok_done and overflow 0 next cycle.
REQ-018 All outputs reflect the character consumed at the previous edge (latency 1 cycle).
REQ-019 IDLE: alpha (MODE 0) or alpha/underscore (MODE 1) -> ALPHA/IDENT, tok_len=1; any other char (digits included) -> stay IDLE, tok_len held.
REQ-020 ALPHA: alpha -> ALPHA; digit -> DIGIT; both tok_len+1; delimiter -> IDLE, no tok_done.
REQ-021 DIGIT: digit -> DIGIT; alpha -> ALPHA (token continues); both tok_len+1; delimiter -> IDLE with tok_done=1.
REQ-022 IDENT: token class -> IDENT, tok_len+1; delimiter -> IDLE with tok_done=1.
REQ-023 match=1 iff state after the edge is DIGIT or IDENT.
REQ-024 On a delimiter, tok_len holds the final length during and after the tok_done cycle until the next token starts.
REQ-025 Token-class char when tok_len=MAX_LEN -> SKIP, overflow=1 one cycle, match=0, tok_len held at MAX_LEN.
REQ-026 SKIP: token-class chars stay SKIP; delimiter -> IDLE with no tok_done.
REQ-027 tok_count increments with every tok_done, wrapping modulo 2^CNT_W.
REQ-028 cnt_clr=1 sets tok_count=0 next edge and wins over a simultaneous increment.
REQ-029 Unused state encodings recover to IDLE on the next edge with all pulses 0.

Reset
REQ-030 rst_n low asynchronously forces IDLE, match=0, tok_done=0, overflow=0, tok_len=0, tok_count=0.
REQ-031 Reset asserted mid-token discards that token; no tok_done after release.
REQ-032 First character consumed is on the first rising edge with rst_n high and in_valid=1.

Verification
REQ-033 MODE 0, "ab12;" -> match 0,0,1,1,0; tok_done=1 after ';' with tok_len=4, tok_count=1.
REQ-034 MODE 0, "1a2b;" -> match 0,0,1,0,0; no tok_done; tok_count=0.
REQ-035 MODE 1, "_x9 " -> match 1,1,1,0; tok_done=1, tok_len=3; then "9 " -> no match, no tok_done.
REQ-036 MODE 0, MAX_LEN=4, "abcd1 " -> overflow=1 after '1', match 0; no tok_done after ' '.
REQ-037 "ab" then 3 cycles in_valid=0 then "3;" -> outputs frozen during gap; match=1 after '3'; tok_done after ';', tok_len=3.
REQ-038 rst_n pulsed low after "ab1" -> all outputs 0 immediately; ";" after release gives no tok_done; cnt_clr coincident with tok_done gives tok_count=0.

Source files
------------

// File: rtl/token_fsm_if.sv
// Character-stream bus for token_fsm: input side (valid/char/clear) and the
// registered token status that comes back.
`timescale 1ns/1ps
interface token_fsm_if #(
  parameter int LEN_W = 6,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [7:0]       in_char;
  logic             cnt_clr;
  logic             match;
  logic             tok_done;
  logic [LEN_W-1:0] tok_len;
  logic [CNT_W-1:0] tok_count;
  logic             overflow;

  modport master (
    output in_valid, in_char, cnt_clr,
    input  match, tok_done, tok_len, tok_count, overflow
  );

  modport slave (
    input  in_valid, in_char, cnt_clr,
    output match, tok_done, tok_len, tok_count, overflow
  );
endinterface

// File: rtl/token_fsm.sv
// Streaming tokenizer: classifies one ASCII character per valid cycle and
// flags matches, completed tokens, token length/count and over-long tokens.
`timescale 1ns/1ps
module token_fsm #(
  parameter int MODE    = 0,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  token_fsm_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALPHA = 3'd1,
    S_DIGIT = 3'd2,
    S_IDENT = 3'd3,
    S_SKIP  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_match, r_done, r_ovf;
  logic             w_done_nxt, w_ovf_nxt;
  logic             w_alpha, w_digit, w_us, w_tok, w_start, w_full;

  // Underscore only belongs to the identifier grammar; in MODE 0 it delimits.
  assign w_alpha = ((bus.in_char >= 8'h41) && (bus.in_char <= 8'h5A)) ||
                   ((bus.in_char >= 8'h61) && (bus.in_char <= 8'h7A));
  assign w_digit = (bus.in_char >= 8'h30) && (bus.in_char <= 8'h39);
  assign w_us    = (MODE == 1) && (bus.in_char == 8'h5F);
  assign w_tok   = w_alpha || w_digit || w_us;
  assign w_start = w_alpha || w_us;
  assign w_full  = (r_len >= LEN_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && w_start) begin
          w_state_nxt = (MODE == 1) ? S_IDENT : S_ALPHA;
          w_len_nxt   = LEN_ONE;
        end
      end
      S_ALPHA, S_DIGIT, S_IDENT: begin
        if (bus.in_valid) begin
          if (w_tok) begin
            if (w_full) begin
              w_state_nxt = S_SKIP;
              w_ovf_nxt   = 1'b1;
            end else begin
              w_len_nxt = r_len + LEN_ONE;
              if (MODE == 1)    w_state_nxt = S_IDENT;
              else if (w_digit) w_state_nxt = S_DIGIT;
              else              w_state_nxt = S_ALPHA;
            end
          end else begin
            // Only a token already in an accepting state completes on delimiter.
            w_state_nxt = S_IDLE;
            w_done_nxt  = (r_state == S_DIGIT) || (r_state == S_IDENT);
          end
        end
      end
      S_SKIP: begin
        if (bus.in_valid && !w_tok) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_match <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_match <= (w_state_nxt == S_DIGIT) || (w_state_nxt == S_IDENT);
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Clear beats a coincident completion; the count wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_cnt <= '0;
    else if (bus.cnt_clr)  r_cnt <= '0;
    else if (w_done_nxt)   r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.match     = r_match;
  assign bus.tok_done  = r_done;
  assign bus.tok_len   = r_len;
  assign bus.tok_count = r_cnt;
  assign bus.overflow  = r_ovf;
endmodule
